calc1_op_scheduler: RTL and testbench

- Shares the two calc1 execution resources between the 4 request ports: the add/sub unit (arith) and the shift unit.
- Each port posts one command. The block queues port IDs per resource in arrival order and grants at most one port per resource per cycle, oldest first.
- Sits between the per-port input pipes and the shared ALU/shifter. It replaces ad-hoc per-port priority logic with strict FIFO fairness.

---
 rtl/calc1_pkg.sv | 23 ++
 rtl/calc1_port_fifo.sv | 66 ++++++
 rtl/calc1_op_scheduler.sv | 112 +++++++++++
 tb/tb_calc1_op_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared command encodings and resource decode for the calc1 operation scheduler.
package calc1_pkg;

  localparam int unsigned CMD_NOP = 0;
  localparam int unsigned CMD_ADD = 1;
  localparam int unsigned CMD_SUB = 2;
  localparam int unsigned CMD_LSH = 5;
  localparam int unsigned CMD_RSH = 6;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ARITH,
    RES_SHIFT
  } res_t;

  // RES_NONE covers both NOP and unknown encodings; callers separate them.
  function automatic res_t cmd_to_res(input logic [31:0] cmd);
    if (cmd == CMD_ADD || cmd == CMD_SUB) return RES_ARITH;
    if (cmd == CMD_LSH || cmd == CMD_RSH) return RES_SHIFT;
    return RES_NONE;
  endfunction

endpackage

// File: rtl/calc1_port_fifo.sv
// FIFO of requesting port IDs: several pushes per cycle in ascending port order, one pop.
module calc1_port_fifo #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned ID_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] push,
  input  logic              pop,
  output logic [ID_W-1:0]   head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IDX_W = $clog2(QDEPTH);

  logic [ID_W-1:0]  mem   [QDEPTH];
  logic [ID_W-1:0]  mem_n [QDEPTH];
  logic [CNT_W-1:0] cnt_n;
  logic             ovf;

  assign head  = mem[0];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(QDEPTH));

  // Head is always slot 0: a pop shifts down first, then pushes fill from the new tail.
  always_comb begin
    mem_n = mem;
    cnt_n = count;
    ovf   = 1'b0;
    if (pop && !empty) begin
      for (int unsigned j = 0; j + 1 < QDEPTH; j++) begin
        mem_n[IDX_W'(j)] = mem[IDX_W'(j + 1)];
      end
      cnt_n = count - CNT_W'(1);
    end
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (push[ID_W'(i)]) begin
        if (cnt_n == CNT_W'(QDEPTH)) begin
          ovf = 1'b1;
        end else begin
          for (int unsigned j = 0; j < QDEPTH; j++) begin
            if (CNT_W'(j) == cnt_n) mem_n[IDX_W'(j)] = ID_W'(i);
          end
          cnt_n = cnt_n + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '{default: '0};
      count <= '0;
    end else begin
      mem   <= mem_n;
      count <= cnt_n;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !ovf);

endmodule

// File: rtl/calc1_op_scheduler.sv
// FIFO-fair scheduler sharing the calc1 arith and shift units among the request ports.
module calc1_op_scheduler
  import calc1_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CMD_W  = 4
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       req_valid,
  input  logic [NPORTS*CMD_W-1:0] req_cmd,
  input  logic                    arith_stall,
  input  logic                    shift_stall,
  output logic [NPORTS-1:0]       arith_gnt,
  output logic [NPORTS-1:0]       shift_gnt,
  output logic [NPORTS-1:0]       pend,
  output logic [NPORTS-1:0]       inval,
  output logic [NPORTS-1:0]       dup_err,
  output logic [$clog2(QDEPTH):0] arith_cnt,
  output logic [$clog2(QDEPTH):0] shift_cnt
);

  localparam int unsigned ID_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Internal vectors are in port order (bit 0 = port 1); ports are MSB-first externally.
  logic [NPORTS-1:0] new_a, new_s, bad, dup;
  logic [NPORTS-1:0] byp_a, byp_s, push_a, push_s;
  logic [NPORTS-1:0] gnt_a_n, gnt_s_n, pend_n;
  logic [NPORTS-1:0] gnt_a_q, gnt_s_q, pend_q, inval_q, dup_q;
  logic              pop_a, pop_s;
  logic [ID_W-1:0]   a_head, s_head;
  logic              a_full, a_empty, s_full, s_empty;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    logic [CMD_W-1:0] cmd;
    logic             live;
    res_t             res;

    assign cmd  = req_cmd[(NPORTS-g)*CMD_W-1 -: CMD_W];
    assign res  = cmd_to_res(32'(cmd));
    assign live = req_valid[NPORTS-1-g] && (cmd != '0);

    assign new_a[g] = live && !pend_q[g] && (res == RES_ARITH);
    assign new_s[g] = live && !pend_q[g] && (res == RES_SHIFT);
    assign bad[g]   = live && !pend_q[g] && (res == RES_NONE);
    assign dup[g]   = live && pend_q[g];

    assign arith_gnt[NPORTS-1-g] = gnt_a_q[g];
    assign shift_gnt[NPORTS-1-g] = gnt_s_q[g];
    assign pend[NPORTS-1-g]      = pend_q[g];
    assign inval[NPORTS-1-g]     = inval_q[g];
    assign dup_err[NPORTS-1-g]   = dup_q[g];
  end

  // x & -x isolates the lowest set bit, i.e. the lowest-numbered new requester.
  always_comb begin
    pop_a   = !a_empty && !arith_stall;
    pop_s   = !s_empty && !shift_stall;
    byp_a   = (a_empty && !arith_stall) ? (new_a & (~new_a + NPORTS'(1))) : '0;
    byp_s   = (s_empty && !shift_stall) ? (new_s & (~new_s + NPORTS'(1))) : '0;
    push_a  = new_a & ~byp_a;
    push_s  = new_s & ~byp_s;
    gnt_a_n = pop_a ? (NPORTS'(1) << a_head) : byp_a;
    gnt_s_n = pop_s ? (NPORTS'(1) << s_head) : byp_s;
    pend_n  = (pend_q & ~gnt_a_n & ~gnt_s_n) | push_a | push_s;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      gnt_a_q <= '0;
      gnt_s_q <= '0;
      pend_q  <= '0;
      inval_q <= '0;
      dup_q   <= '0;
    end else begin
      gnt_a_q <= gnt_a_n;
      gnt_s_q <= gnt_s_n;
      pend_q  <= pend_n;
      inval_q <= bad;
      dup_q   <= dup;
    end
  end

  calc1_port_fifo #(.NPORTS(NPORTS), .QDEPTH(QDEPTH)) u_arith_q (
    .clk   (c_clk),
    .rst   (reset),
    .push  (push_a),
    .pop   (pop_a),
    .head  (a_head),
    .count (arith_cnt),
    .full  (a_full),
    .empty (a_empty)
  );

  calc1_port_fifo #(.NPORTS(NPORTS), .QDEPTH(QDEPTH)) u_shift_q (
    .clk   (c_clk),
    .rst   (reset),
    .push  (push_s),
    .pop   (pop_s),
    .head  (s_head),
    .count (shift_cnt),
    .full  (s_full),
    .empty (s_empty)
  );

  arith_no_ovf: assert property (@(posedge c_clk) disable iff (reset)
    !(a_full && !pop_a && (push_a != '0)));
  shift_no_ovf: assert property (@(posedge c_clk) disable iff (reset)
    !(s_full && !pop_s && (push_s != '0)));

endmodule

// File: tb/tb_calc1_op_scheduler.sv
// Scoreboard bench: queue-based reference model of the scheduler, randomized and directed traffic.
module tb_calc1_op_scheduler;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_cmd = '0;
  logic        arith_stall = 1'b0;
  logic        shift_stall = 1'b0;
  logic [3:0]  arith_gnt, shift_gnt, pend, inval, dup_err;
  logic [2:0]  arith_cnt, shift_cnt;

  calc1_op_scheduler #(.NPORTS(4), .QDEPTH(4), .CMD_W(4)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .arith_stall (arith_stall),
    .shift_stall (shift_stall),
    .arith_gnt   (arith_gnt),
    .shift_gnt   (shift_gnt),
    .pend        (pend),
    .inval       (inval),
    .dup_err     (dup_err),
    .arith_cnt   (arith_cnt),
    .shift_cnt   (shift_cnt)
  );

  always #5 c_clk = ~c_clk;

  int checks = 0;
  int passed = 0;
  int edge_no = 0;
  always @(posedge c_clk) edge_no <= edge_no + 1;

  typedef struct { int tag; logic [3:0] mask; } gexp_t;
  typedef struct { int tag; logic [3:0] pend; logic [3:0] inval; logic [3:0] dup; int acnt; int scnt; } sexp_t;

  gexp_t ga_q[$];
  gexp_t gs_q[$];
  sexp_t st_q[$];

  // Reference model state: port numbers 0..3 stand for ports 1..4.
  int mqa[$];
  int mqs[$];
  bit mpend[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_no, act, exp);
  endtask

  function automatic logic [3:0] bitm(input int p);
    logic [3:0] m;
    m = 4'b1000;
    return m >> p;
  endfunction

  // 1 = arith, 2 = shift, 0 = nop, 3 = invalid
  function automatic int dec(input logic [3:0] c);
    case (c)
      4'd0:       return 0;
      4'd1, 4'd2: return 1;
      4'd5, 4'd6: return 2;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [15:0] pk(input int c1, input int c2, input int c3, input int c4);
    return {c1[3:0], c2[3:0], c3[3:0], c4[3:0]};
  endfunction

  function automatic logic [3:0] pend_mask();
    logic [3:0] m;
    m = '0;
    for (int p = 0; p < 4; p++) if (mpend[p]) m |= bitm(p);
    return m;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic [15:0] c, input logic sa, input logic ss);
    int na[$];
    int ns[$];
    int gi;
    sexp_t s;
    gexp_t g;
    s.tag = edge_no + 1;
    s.inval = '0;
    s.dup = '0;
    for (int p = 0; p < 4; p++) begin
      logic [3:0] c4;
      c4 = c[15-4*p -: 4];
      if (v[3-p] && c4 != 0) begin
        if (mpend[p]) s.dup |= bitm(p);
        else begin
          case (dec(c4))
            1:       na.push_back(p);
            2:       ns.push_back(p);
            default: s.inval |= bitm(p);
          endcase
        end
      end
    end
    gi = -1;
    if (!sa) begin
      if (mqa.size() > 0) gi = mqa.pop_front();
      else if (na.size() > 0) gi = na.pop_front();
    end
    foreach (na[k]) begin mqa.push_back(na[k]); mpend[na[k]] = 1; end
    if (gi >= 0) begin
      mpend[gi] = 0;
      g.tag = edge_no + 1; g.mask = bitm(gi);
      ga_q.push_back(g);
    end
    gi = -1;
    if (!ss) begin
      if (mqs.size() > 0) gi = mqs.pop_front();
      else if (ns.size() > 0) gi = ns.pop_front();
    end
    foreach (ns[k]) begin mqs.push_back(ns[k]); mpend[ns[k]] = 1; end
    if (gi >= 0) begin
      mpend[gi] = 0;
      g.tag = edge_no + 1; g.mask = bitm(gi);
      gs_q.push_back(g);
    end
    s.pend = pend_mask();
    s.acnt = mqa.size();
    s.scnt = mqs.size();
    st_q.push_back(s);
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] c, input logic sa, input logic ss);
    @(negedge c_clk);
    reset = 1'b0;
    req_valid = v;
    req_cmd = c;
    arith_stall = sa;
    shift_stall = ss;
    model_step(v, c, sa, ss);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    sexp_t s;
    @(negedge c_clk);
    reset = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    arith_stall = 1'b0;
    shift_stall = 1'b0;
    mqa.delete();
    mqs.delete();
    for (int p = 0; p < 4; p++) mpend[p] = 0;
    s.tag = edge_no + 1; s.pend = '0; s.inval = '0; s.dup = '0; s.acnt = 0; s.scnt = 0;
    st_q.push_back(s);
    #1;
    chk("rst_arith_gnt", arith_gnt, 0);
    chk("rst_shift_gnt", shift_gnt, 0);
    chk("rst_pend", pend, 0);
    chk("rst_arith_cnt", arith_cnt, 0);
    chk("rst_shift_cnt", shift_cnt, 0);
  endtask

  // Monitor: compares whatever the DUT presents after each edge against the scoreboard.
  initial begin
    forever begin
      logic [3:0] exp;
      sexp_t s;
      @(posedge c_clk);
      #1;
      if (st_q.size() > 0 && st_q[0].tag == edge_no) begin
        s = st_q.pop_front();
        chk("pend", pend, s.pend);
        chk("inval", inval, s.inval);
        chk("dup_err", dup_err, s.dup);
        chk("arith_cnt", arith_cnt, s.acnt);
        chk("shift_cnt", shift_cnt, s.scnt);
      end
      exp = '0;
      if (ga_q.size() > 0 && ga_q[0].tag == edge_no) exp = ga_q.pop_front().mask;
      if (arith_gnt != 0 || exp != 0) chk("arith_gnt", arith_gnt, exp);
      exp = '0;
      if (gs_q.size() > 0 && gs_q[0].tag == edge_no) exp = gs_q.pop_front().mask;
      if (shift_gnt != 0 || exp != 0) chk("shift_gnt", shift_gnt, exp);
    end
  end

  initial begin
    do_reset();
    idle(2);
    // single ADD on port 3
    drive(4'b0010, pk(0, 0, 1, 0), 1'b0, 1'b0);
    idle(3);
    // SUB on all four ports at once
    drive(4'b1111, pk(2, 2, 2, 2), 1'b0, 1'b0);
    idle(6);
    // port 2 LSH with port 4 ADD
    drive(4'b0101, pk(0, 5, 0, 1), 1'b0, 1'b0);
    idle(3);
    // port 1 ADD under a 3-cycle arith stall, then port 2 ADD
    drive(4'b1000, pk(1, 0, 0, 0), 1'b1, 1'b0);
    drive(4'b0000, pk(0, 0, 0, 0), 1'b1, 1'b0);
    drive(4'b0000, pk(0, 0, 0, 0), 1'b1, 1'b0);
    drive(4'b0100, pk(0, 1, 0, 0), 1'b0, 1'b0);
    idle(4);
    // invalid command, then duplicate while pending
    drive(4'b0100, pk(0, 4, 0, 0), 1'b0, 1'b0);
    idle(2);
    drive(4'b0100, pk(0, 1, 0, 0), 1'b1, 1'b0);
    drive(4'b0100, pk(0, 1, 0, 0), 1'b1, 1'b0);
    idle(4);
    // three ports queued, reset mid-sequence
    drive(4'b1110, pk(1, 2, 1, 0), 1'b1, 1'b0);
    drive(4'b0000, pk(0, 0, 0, 0), 1'b1, 1'b0);
    do_reset();
    idle(6);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  v;
      logic [15:0] c;
      int          tbl[8];
      tbl = '{1, 2, 5, 6, 1, 5, 0, 2};
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        for (int p = 0; p < 4; p++) begin
          int r;
          r = $urandom_range(0, 9);
          c[15-4*p -: 4] = (r < 8) ? 4'(tbl[r]) : 4'($urandom_range(0, 15));
        end
        v = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) v = v & 4'($urandom_range(0, 15));
        drive(v, c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
    end
    idle(8);
    @(posedge c_clk);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
